mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds on the CPU data-memory bus, the same dmem_wren/dmem_address/dmem_data_in/funct3/dmem_data_out interface the core drives into memory. CPU stores push bytes into a TX FIFO, and loads read status and the baud divisor. A serializer drains the FIFO onto a single 8N1 line, LSB first. The block sits beside memory; top muxes dmem_data_out using sel_q.

Parameters:
BASE_ADDR, 32'hFFFF_FFE0, word-aligned base of the 16-byte register window.
FIFO_DEPTH, 8, TX FIFO entries; must be a power of two and at least 2.
DEFAULT_DIV, 16'd1250, baud divisor at reset, in clk cycles per bit (12 MHz / 9600).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
dmem_wren  input  1  store strobe, one cycle per store.
dmem_address  input  32  byte address from the core.
dmem_data_in  input  32  store data.
funct3  input  3  access size; 000 = byte, 001 = half, 010 = word.
dmem_data_out  output  32  registered read data.
sel_q  output  1  registered address-hit flag, aligned with dmem_data_out.
tx  output  1  serial line, idle high.
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Decode: hit = dmem_address[31:4] == BASE_ADDR[31:4]; offset = dmem_address[3:2].
- Register map:
  - 0 TXDATA: write-only. A store of any size pushes dmem_data_in[7:0]. Reads return 0.
  - 1 STATUS: read-only except bit 3. bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky), bits[7:4] FIFO count (saturates at 15), other bits 0. Writing 1 to bit3 clears overflow.
  - 2 BAUD: RW, low 16 bits. A written value of 0 is stored as 1. Requires funct3 = 010; narrower stores are ignored.
  - 3: reserved. Reads return 0, writes are ignored.
- Read latency: exactly 1 cycle. dmem_data_out and sel_q register at the posedge after the address is presented, matching memory. When sel_q = 0, dmem_data_out = 0.
- FIFO full: a push is dropped, overflow sets, and FIFO contents are unchanged.
- Simultaneous push and pop on a full FIFO is allowed; the count stays constant.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE: when the FIFO is non-empty, pop into shift_q, latch the divisor into div_q, and go to START.
- START: tx = 0 for div_q cycles, then go to DATA.
- DATA: shift out 8 bits LSB first, div_q cycles each; bit index runs 0 to 7, then go to STOP.
- STOP: tx = 1 for div_q cycles. If the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Bit timer: counts 0 to div_q - 1, and the bit ends on the wrap.
- Frame length: exactly 10*div_q cycles.
- A BAUD write mid-frame does not disturb the current frame; it takes effect at the next pop.
- Push latency: a store to TXDATA at posedge N with the FSM in IDLE gives fifo non-empty at N+1. The FSM pops at posedge N+2, and tx is 0 from N+2.
- tx is registered; there is no combinational path from the bus to tx.
- Reset while reset_n is low: tx = 1, FSM = IDLE, FIFO flushed, overflow = 0, BAUD = DEFAULT_DIV, dmem_data_out = 0, sel_q = 0, tx_busy = 0. A frame in progress is abandoned immediately.

Optional Feature:
- Macro: MMIO_UART_TX_PARITY_EN.
- Defined: STATUS bit8 is RW parity_on, reset 0. When parity_on = 1, a PARITY state between DATA and STOP sends the even-parity bit (XOR of the 8 data bits) for div_q cycles, giving an 11*div_q frame.
- Undefined: STATUS bit8 reads 0, there is no PARITY state, and the frame is always 10*div_q.

Decomposition:
- Package mmio_uart_pkg: register offset localparams (OFF_TXDATA, OFF_STATUS, OFF_BAUD), STATUS bit-position constants, and typedef enum logic [2:0] uart_tx_state_t.
- Sub-module sync_fifo (params WIDTH, DEPTH): ports clk, reset_n, push, pop, din, dout, full, empty, count. Pointers are one bit wider than the address for full/empty detection.

Test Plan:
- Reset default read: reset, then load STATUS -> next cycle dmem_data_out = 0x0000_0002, sel_q = 1; load BAUD -> 0x0000_04E2.
- Single byte frame: write BAUD = 4, store 0x55 to TXDATA -> tx low 2 cycles after the store, then bits 1,0,1,0,1,0,1,0, then high, each held 4 cycles. Frame = 40 cycles; tx_busy falls after the stop bit.
- Back-to-back: push 0xA5 then 0x3C with BAUD = 2 -> two consecutive 20-cycle frames, second start bit immediately after the first stop bit.
- Overflow: with BAUD = 1000, push 10 bytes quickly -> STATUS full = 1, overflow = 1, count = 8 (first byte already popped, so at most 9 bytes are sent). Write STATUS 0x8 -> overflow = 0.
- Reset mid-frame: assert reset_n low during DATA -> tx = 1 in the same cycle, empty = 1 after release, no further frame.
- Address miss and divisor edge case: load an address outside the window -> sel_q = 0, dmem_data_out = 0. Write BAUD = 0 -> reads back 1, bits last 1 cycle. With the macro defined and parity on, 0x07 -> parity bit 1.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serializer state encoding.
// Optional build macro: MMIO_UART_TX_PARITY_EN adds the PARITY state.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;

  localparam int unsigned SB_FULL    = 0;
  localparam int unsigned SB_EMPTY   = 1;
  localparam int unsigned SB_BUSY    = 2;
  localparam int unsigned SB_OVF     = 3;
  localparam int unsigned SB_CNT_LSB = 4;
  localparam int unsigned SB_PARITY  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef MMIO_UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with one-bit-wider pointers for full/empty detection.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
// Optional build macro: MMIO_UART_TX_PARITY_EN (STATUS bit8 parity_on, PARITY state).
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd1250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic [2:0]  funct3,
  output logic [31:0] dmem_data_out,
  output logic        sel_q,
  output logic        tx,
  output logic        tx_busy
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic           hit, wr_hit;
  logic [1:0]     offset;
  logic [31:0]    rdata_d, rdata_q;
  logic [15:0]    baud_q;
  logic           ovf_q;
  logic           push_q;
  logic [7:0]     push_data_q;
  logic           pop, full, empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  count;
  logic [31:0]    count32;
  logic [3:0]     count_sat;
  uart_tx_state_t state_q;
  logic [15:0]    div_q, cnt_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           wrap;
  logic           unused;
`ifdef MMIO_UART_TX_PARITY_EN
  logic           parity_q;
`endif

  assign hit       = (dmem_address[31:4] == BASE_ADDR[31:4]);
  assign offset    = dmem_address[3:2];
  assign wr_hit    = dmem_wren & hit;
  assign count32   = 32'(count);
  assign count_sat = (count32 > 32'd15) ? 4'hF : count32[3:0];
  assign wrap      = (cnt_q == div_q - 16'd1);
  assign tx_busy   = (state_q != ST_IDLE) | ~empty;
  assign tx        = tx_q;
  assign dmem_data_out = rdata_q;
  assign unused    = ^{dmem_address[1:0], dmem_data_in[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push_q),
    .pop    (pop),
    .din    (push_data_q),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // Read-data mux for the register window
  always_comb begin
    rdata_d = '0;
    case (offset)
      OFF_STATUS: begin
        rdata_d[SB_FULL]             = full;
        rdata_d[SB_EMPTY]            = empty;
        rdata_d[SB_BUSY]             = tx_busy;
        rdata_d[SB_OVF]              = ovf_q;
        rdata_d[SB_CNT_LSB +: 4]     = count_sat;
`ifdef MMIO_UART_TX_PARITY_EN
        rdata_d[SB_PARITY]           = parity_q;
`endif
      end
      OFF_BAUD: rdata_d[15:0] = baud_q;
      default:  rdata_d = '0;
    endcase
  end

  // Registered read response, one cycle after the address like memory
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      sel_q   <= hit;
      rdata_q <= hit ? rdata_d : '0;
    end
  end

  // Control registers; TXDATA push is staged one cycle before entering the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_q      <= DEFAULT_DIV;
      ovf_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      push_q      <= wr_hit && (offset == OFF_TXDATA);
      push_data_q <= dmem_data_in[7:0];
      if (wr_hit && (offset == OFF_BAUD) && (funct3 == 3'b010))
        baud_q <= (dmem_data_in[15:0] == 16'd0) ? 16'd1 : dmem_data_in[15:0];
      if (push_q && full && !pop)
        ovf_q <= 1'b1;
      else if (wr_hit && (offset == OFF_STATUS) && dmem_data_in[SB_OVF])
        ovf_q <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
      if (wr_hit && (offset == OFF_STATUS))
        parity_q <= dmem_data_in[SB_PARITY];
`endif
    end
  end

  // FIFO pop request: on leaving IDLE or at the end of a stop bit
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      case (state_q)
        ST_IDLE: pop = 1'b1;
        ST_STOP: pop = wrap;
        default: pop = 1'b0;
      endcase
    end
  end

  // Serializer FSM with registered tx
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      div_q     <= DEFAULT_DIV;
    end else begin
      cnt_q <= wrap ? 16'd0 : cnt_q + 16'd1;
      case (state_q)
        ST_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (!empty) begin
            shift_q <= fifo_dout;
            div_q   <= baud_q;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (wrap) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wrap) begin
            if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              if (parity_q) begin
                tx_q    <= ^shift_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (wrap) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (wrap) begin
            if (!empty) begin
              shift_q <= fifo_dout;
              div_q   <= baud_q;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_FFE0;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FFE4;
  localparam logic [31:0] A_BAUD   = 32'hFFFF_FFE8;
  localparam logic [31:0] A_RSVD   = 32'hFFFF_FFEC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = '0;
  logic [31:0] dmem_data_in = '0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] dmem_data_out;
  logic        sel_q;
  logic        tx;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dmem_wren    (dmem_wren),
    .dmem_address (dmem_address),
    .dmem_data_in (dmem_data_in),
    .funct3       (funct3),
    .dmem_data_out(dmem_data_out),
    .sel_q        (sel_q),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level j cycles after the start bit begins
  function automatic logic exp_tx(input logic [7:0] d, input int div, input int j, input bit par);
    int b;
    b = j / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    dmem_wren = 1'b1; dmem_address = a; dmem_data_in = d; funct3 = f3;
    @(posedge clk); #1;
    dmem_wren = 1'b0; dmem_address = '0; dmem_data_in = '0; funct3 = 3'b010;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clk);
    dmem_wren = 1'b0; dmem_address = a;
    @(posedge clk); #1;
    d = dmem_data_out; s = sel_q;
    dmem_address = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk); #2;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic s;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || sel_q !== 1'b0 || dmem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b busy=%b sel=%b dout=%h, required 1 0 0 00000000", tx, tx_busy, sel_q, dmem_data_out);
    end
    @(negedge clk); reset_n = 1'b1;
    bus_read(A_STATUS, d, s);
    checks++;
    if (d !== 32'h0000_0002 || s !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: got %h sel=%b, required 00000002 sel=1", d, s);
    end
    bus_read(A_BAUD, d, s);
    checks++;
    if (d !== 32'h0000_04E2 || s !== 1'b1) begin
      errors++;
      $display("FAIL reset_baud: got %h sel=%b, required 000004e2 sel=1", d, s);
    end
  endtask

  task automatic test_single_frame();
    bus_write(A_BAUD, 32'd4, 3'b010);
    bus_write(A_TXDATA, 32'h0000_0055, 3'b000);
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pre_start: tx=%b busy=%b, required 1 1", tx, tx_busy);
    end
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== exp_tx(8'h55, 4, j, 1'b0) || tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL single_bit[%0d]: tx=%b busy=%b, required tx=%b busy=1", j, tx, tx_busy, exp_tx(8'h55, 4, j, 1'b0));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: tx=%b busy=%b, required 1 0", tx, tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    bus_write(A_BAUD, 32'd2, 3'b010);
    bus_write(A_TXDATA, 32'h0000_00A5, 3'b000);
    bus_write(A_TXDATA, 32'h0000_003C, 3'b000);
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      exp = (j < 20) ? exp_tx(8'hA5, 2, j, 1'b0) : exp_tx(8'h3C, 2, j - 20, 1'b0);
      checks++;
      if (tx !== exp) begin
        errors++;
        $display("FAIL b2b_bit[%0d]: tx=%b, required %b", j, tx, exp);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: tx=%b busy=%b, required 1 0", tx, tx_busy);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic s;
    bus_write(A_BAUD, 32'd1000, 3'b010);
    for (int i = 0; i < 10; i++) bus_write(A_TXDATA, 32'(i), 3'b000);
    repeat (3) @(posedge clk);
    bus_read(A_STATUS, d, s);
    checks++;
    if (d !== 32'h0000_008D) begin
      errors++;
      $display("FAIL overflow_status: got %h, required 0000008d", d);
    end
    bus_write(A_STATUS, 32'h0000_0008, 3'b010);
    bus_read(A_STATUS, d, s);
    checks++;
    if (d !== 32'h0000_0085) begin
      errors++;
      $display("FAIL overflow_clear: got %h, required 00000085", d);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic s; logic stayed_high;
    bus_write(A_BAUD, 32'd4, 3'b010);
    bus_write(A_TXDATA, 32'h0000_0000, 3'b000);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_data_bit: tx=%b, required 0", tx);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: tx=%b busy=%b, required 1 0", tx, tx_busy);
    end
    @(negedge clk); reset_n = 1'b1;
    bus_read(A_STATUS, d, s);
    checks++;
    if (d !== 32'h0000_0002) begin
      errors++;
      $display("FAIL mid_reset_status: got %h, required 00000002", d);
    end
    bus_read(A_BAUD, d, s);
    checks++;
    if (d !== 32'h0000_04E2) begin
      errors++;
      $display("FAIL mid_reset_baud: got %h, required 000004e2", d);
    end
    stayed_high = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    checks++;
    if (stayed_high !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_no_frame: tx left idle, required constant 1");
    end
  endtask

  task automatic test_addr_and_div();
    logic [31:0] d; logic s;
    bus_read(32'h0000_1000, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b0) begin
      errors++;
      $display("FAIL addr_miss: got %h sel=%b, required 00000000 sel=0", d, s);
    end
    bus_read(A_RSVD, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b1) begin
      errors++;
      $display("FAIL addr_reserved: got %h sel=%b, required 00000000 sel=1", d, s);
    end
    bus_read(A_TXDATA, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b1) begin
      errors++;
      $display("FAIL txdata_read: got %h sel=%b, required 00000000 sel=1", d, s);
    end
    bus_write(A_BAUD, 32'd0, 3'b010);
    bus_read(A_BAUD, d, s);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++;
      $display("FAIL baud_zero: got %h, required 00000001", d);
    end
    bus_write(A_BAUD, 32'd5, 3'b000);
    bus_read(A_BAUD, d, s);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++;
      $display("FAIL baud_byte_ignored: got %h, required 00000001", d);
    end
    bus_write(A_TXDATA, 32'h0000_00C3, 3'b000);
    @(posedge clk);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== exp_tx(8'hC3, 1, j, 1'b0)) begin
        errors++;
        $display("FAIL div1_bit[%0d]: tx=%b, required %b", j, tx, exp_tx(8'hC3, 1, j, 1'b0));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL div1_end: tx=%b busy=%b, required 1 0", tx, tx_busy);
    end
  endtask

`ifdef MMIO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [31:0] d; logic s;
    bus_write(A_STATUS, 32'h0000_0100, 3'b010);
    bus_read(A_STATUS, d, s);
    checks++;
    if (d !== 32'h0000_0102) begin
      errors++;
      $display("FAIL parity_on_read: got %h, required 00000102", d);
    end
    bus_write(A_TXDATA, 32'h0000_0007, 3'b000);
    @(posedge clk);
    for (int j = 0; j < 11; j++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== exp_tx(8'h07, 1, j, 1'b1)) begin
        errors++;
        $display("FAIL parity_bit[%0d]: tx=%b, required %b", j, tx, exp_tx(8'h07, 1, j, 1'b1));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL parity_end: tx=%b busy=%b, required 1 0", tx, tx_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_addr_and_div();
`ifdef MMIO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
